// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and load/store.
// Data accesses win over fetches; a stuck memory is aborted after TIMEOUT busy cycles.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_ren,
  output logic              m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_busy,
  output logic              stall,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] busy_cnt;
  logic             d_pending;
  logic             i_pending;
  logic             timeout_hit;
  logic             done;

  // A port whose ack is high this cycle has already been served; its held
  // request must neither stall the CPU nor be granted again.
  assign d_pending   = (d_ren | d_wen) & ~d_ack;
  assign i_pending   = i_req & ~i_ack;
  assign stall       = d_pending | i_pending;

  assign timeout_hit = m_busy & (busy_cnt == CNT_LAST);
  assign done        = ~m_busy | timeout_hit;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= IDLE;
      busy_cnt <= '0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      err      <= 1'b0;
      m_ren    <= 1'b0;
      m_wen    <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          busy_cnt <= '0;
          if (d_pending) begin
            state   <= DATA;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_wen   <= d_wen;
            m_ren   <= ~d_wen;
          end else if (i_pending) begin
            state  <= FETCH;
            m_addr <= i_addr;
            m_ren  <= 1'b1;
            m_wen  <= 1'b0;
          end
        end
        FETCH, DATA: begin
          if (done) begin
            state <= IDLE;
            m_ren <= 1'b0;
            m_wen <= 1'b0;
            err   <= timeout_hit;
            if (state == FETCH) begin
              i_ack   <= 1'b1;
              i_rdata <= timeout_hit ? '0 : m_rdata;
            end else begin
              d_ack <= 1'b1;
              // Stores return nothing, so the last load result is kept.
              if (!m_wen) d_rdata <= timeout_hit ? '0 : m_rdata;
            end
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the CPU instruction-fetch path and the load/store path.
- Serialises the two requesters onto one memory handshake and returns read data to the correct requester.
- Drives a stall to top-level sequencing so the PC and register-file writes freeze while an access is outstanding.
- Aborts any memory transaction that exceeds a busy-cycle timeout and flags an error.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- TIMEOUT, 16, maximum consecutive m_busy cycles before abort (must be ≥ 1)

Ports:
- clk  in  1  system clock, all state on rising edge
- nrst  in  1  reset; one clock; reset is synchronous and active-low
- i_req  in  1  fetch request; held with i_addr until i_ack
- i_addr  in  ADDR_W  fetch address (the PC)
- i_rdata  out  DATA_W  fetched instruction, valid while i_ack=1
- i_ack  out  1  one-cycle completion pulse for fetch
- d_ren  in  1  load request; held until d_ack
- d_wen  in  1  store request; held until d_ack
- d_addr  in  ADDR_W  load/store address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid while d_ack=1
- d_ack  out  1  one-cycle completion pulse for load/store
- m_ren  out  1  memory read strobe (registered)
- m_wen  out  1  memory write strobe (registered)
- m_addr  out  ADDR_W  memory address (registered)
- m_wdata  out  DATA_W  memory write data (registered)
- m_rdata  in  DATA_W  memory read data
- m_busy  in  1  memory not yet complete
- stall  out  1  combinational freeze request to CPU
- err  out  1  one-cycle pulse coincident with an ack when that access timed out

Behaviour:
- Reset (nrst=0 at a rising edge):
  - Go to IDLE.
  - Clear i_ack, d_ack, m_ren, m_wen, err and the timeout counter.
  - Clear m_addr, m_wdata, i_rdata and d_rdata to 0.
  - Reset mid-transaction abandons the access; the strobes drop at that edge and no ack is issued.
- States: IDLE, FETCH, DATA.
- IDLE arbitration, evaluated at each edge:
  - A data request (d_ren|d_wen) has fixed priority over i_req; it belongs to the instruction already executing.
  - A port whose ack is high this cycle is ignored, so a held request is not re-granted.
  - Data grant: go to DATA, register m_addr=d_addr and m_wdata=d_wdata.
    - If d_wen=1, set m_wen=1 and m_ren=0; a store wins even if d_ren is also high.
    - Otherwise set m_ren=1.
  - Fetch grant: go to FETCH, register m_addr=i_addr and m_ren=1.
  - Counter cleared on grant.
- FETCH/DATA: strobes, m_addr and m_wdata are held stable.
  - Edge with m_busy=0:
    - Capture m_rdata into i_rdata (FETCH) or d_rdata (DATA); on a store, d_rdata is left unchanged.
    - Pulse the matching ack for exactly one cycle, clear both strobes, return to IDLE.
  - Edge with m_busy=1:
    - Counter increments.
    - When the counter reaches TIMEOUT-1 at that edge, treat as completion: rdata=0, ack and err pulse together, strobes clear, return to IDLE.
- Latency:
  - Request seen at edge N → strobe high from edge N → ack high in the cycle after the first edge with m_busy=0.
  - Zero-wait memory gives ack in cycle N+2.
- Back-to-back: with both requests pending, the data access completes first, then the fetch is granted on the first IDLE edge after d_ack. Minimum one IDLE cycle between accesses.
- stall = ((d_ren|d_wen) & ~d_ack) | (i_req & ~i_ack).
- Requests dropped before ack are a protocol violation. The transaction still completes, and the ack pulses with no consumer.

Test Plan:
- Zero-wait fetch: nrst released, i_req=1, i_addr=0x0, m_busy=0, m_rdata=0x3E800093 → m_ren=1 with m_addr=0x0 one cycle; i_ack=1 and i_rdata=0x3E800093 at cycle N+2; stall=0 in the ack cycle.
- Simultaneous requests: i_req=1 (addr 0x8) and d_ren=1 (addr 0x100, m_rdata=0x1234) same cycle → DATA served first, d_rdata=0x1234 with d_ack; then m_addr=0x8 fetch and i_ack; stall high until the respective ack.
- Store with wait states: d_wen=1, d_addr=0x200, d_wdata=0xDEADBEEF, m_busy high 3 edges → m_wen held 4 cycles with stable addr/data, m_ren=0, d_ack one cycle after busy drops, d_rdata unchanged.
- Timeout: TIMEOUT=4, i_req=1, m_busy stuck 1 → i_ack and err pulse together after 4 busy edges, i_rdata=0, state returns to IDLE, next request granted.
- Reset mid-access: assert nrst=0 while in DATA with m_busy=1 → next edge m_ren=m_wen=0, no d_ack, all outputs 0; after release, a fresh fetch completes normally.
- Held request not regranted: d_ren held high one extra cycle after d_ack → no second memory strobe in that cycle.
